// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX framer and RX side.
// State encoding, frame length helper and idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int frame_len(
        input int data_w,
        input int parity_en,
        input int stop_bits
    );
        return 1 + data_w + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: counts 0..OVERSAMPLE-1, pulses bit_end on wrap.
// Shared by the TX framer and the RX sampler.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 8,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          bit_end
);

    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    assign bit_end = (cnt == CNT_LAST);

    // Explicit wrap at OVERSAMPLE-1 so non-power-of-2 values never overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// Every line output is registered; tx_ready decodes the state.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_dataout,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW =
        $clog2(frame_len(DATA_W, PARITY_EN, STOP_BITS));

    localparam logic [CW-1:0] CNT_PRE   = CW'(OVERSAMPLE - 2);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_W - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     bit_idx;
    logic              par_bit;
    logic [CW-1:0]     cnt;
    logic              bit_end;
    logic              timer_clr;

    assign tx_ready  = (state == IDLE);
    assign timer_clr = (state == IDLE);

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE),
        .CW        (CW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clr),
        .cnt    (cnt),
        .bit_end(bit_end)
    );

    // Frame sequencer; line level is set for the bit being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            par_bit    <= 1'b0;
            tx_dataout <= IDLE_LEVEL;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx_dataout <= IDLE_LEVEL;
                    if (tx_valid) begin
                        state      <= START;
                        shreg      <= tx_data;
                        par_bit    <= (^tx_data) ^ ODD;
                        bit_idx    <= '0;
                        tx_dataout <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state      <= DATA;
                        tx_dataout <= shreg[0];
                        shreg      <= shreg >> 1;
                        bit_idx    <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state      <= PARITY;
                                tx_dataout <= par_bit;
                            end else begin
                                state      <= STOP;
                                tx_dataout <= IDLE_LEVEL;
                            end
                        end else begin
                            tx_dataout <= shreg[0];
                            shreg      <= shreg >> 1;
                            bit_idx    <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state      <= STOP;
                        tx_dataout <= IDLE_LEVEL;
                    end
                end
                STOP: begin
                    // done is registered one clock early so it
                    // coincides with the final stop-bit clock
                    if (bit_idx == LAST_STOP && cnt == CNT_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (bit_idx == LAST_STOP) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations share one stimulus.
// A frame-level model is checked every cycle plus literal pins.
module tb_uart_tx_frame;

    localparam int N  = 4;
    localparam int OS = 8;
    localparam int PE[N] = '{0, 1, 1, 0};
    localparam int PO[N] = '{0, 0, 1, 0};
    localparam int SB[N] = '{1, 1, 1, 2};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   tx_data = 8'h00;
    logic         tx_valid = 1'b0;
    logic [N-1:0] ready;
    logic [N-1:0] dout;
    logic [N-1:0] busy;
    logic [N-1:0] done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx_frame #(
            .OVERSAMPLE(OS),
            .DATA_W    (8),
            .PARITY_EN (PE[g]),
            .PARITY_ODD(PO[g]),
            .STOP_BITS (SB[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_data   (tx_data),
            .tx_valid  (tx_valid),
            .tx_ready  (ready[g]),
            .tx_dataout(dout[g]),
            .tx_busy   (busy[g]),
            .tx_done   (done[g])
        );
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Model: a frame is a bit vector played out OS clocks per bit;
    // rem counts clocks of line time left, 0 means idle/ready.
    int          rem[N] = '{default: 0};
    int          flen[N] = '{default: 0};
    logic [15:0] fr[N];

    function automatic logic [15:0] mkframe(input logic [7:0] d,
                                            input int pe,
                                            input int po);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (pe != 0) f[9] = (^d) ^ (po != 0);
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) rem[k] = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (rem[k] == 0) begin
                    if (tx_valid) begin
                        fr[k] = mkframe(tx_data, PE[k], PO[k]);
                        rem[k] = (1 + 8 + PE[k] + SB[k]) * OS;
                        flen[k] = rem[k];
                    end
                end else begin
                    rem[k] = rem[k] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            logic el;
            el = (rem[k] == 0) ? 1'b1 :
                 fr[k][(flen[k] - rem[k]) / OS];
            chk($sformatf("line%0d", k), 32'(dout[k]), 32'(el));
            chk($sformatf("busy%0d", k), 32'(busy[k]),
                32'(rem[k] > 0));
            chk($sformatf("ready%0d", k), 32'(ready[k]),
                32'(rem[k] == 0));
            chk($sformatf("done%0d", k), 32'(done[k]),
                32'(rem[k] == 1));
        end
    end

    int          dn[N];
    logic [15:0] smp[N];

    // Called on the first negedge after an accept edge
    task automatic watch(input int ncyc);
        for (int k = 0; k < N; k++) begin
            dn[k] = 0;
            smp[k] = '1;
        end
        for (int n = 1; n <= ncyc; n++) begin
            for (int k = 0; k < N; k++) begin
                if (done[k] === 1'b1 && dn[k] == 0) dn[k] = n;
                if (n % OS == OS / 2 && n / OS < 16)
                    smp[k][n/OS] = dout[k];
            end
            if (n < ncyc) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int lim);
        int c;
        c = 0;
        while (ready !== 4'hF && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk("idle_timeout", 32'(ready), 32'hF);
    endtask

    task automatic send1(input logic [7:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        int       done_at, low_at, rdy_cnt;
        logic [9:0] b2;
        logic [7:0] b3;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'hF);
        chk("rst_line", 32'(dout), 32'hF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send1(8'hA5);
        watch(100);
        chk("a5_bits", 32'(smp[0][9:0]), 32'h34A);
        chk("a5_done", dn[0], 80);
        chk("par_e_done", dn[1], 88);
        chk("par_o_done", dn[2], 88);
        chk("stop2_done", dn[3], 88);
        wait_idle(50);

        send1(8'h07);
        watch(100);
        chk("par_even_frame", 32'(smp[1][10:0]), 32'h60E);
        chk("par_odd_frame", 32'(smp[2][10:0]), 32'h40E);
        chk("stop2_frame", 32'(smp[3][10:0]), 32'h60E);
        chk("stop2_done07", dn[3], 88);
        wait_idle(50);

        tx_data = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hAA;
        done_at = 0;
        low_at = 0;
        rdy_cnt = 0;
        b2 = '0;
        for (int n = 1; n <= 170; n++) begin
            if (n == 100) tx_valid = 1'b0;
            if (done[0] === 1'b1 && done_at == 0) done_at = n;
            if (done_at != 0 && low_at == 0 && dout[0] === 1'b0)
                low_at = n;
            if (n <= 160 && ready[0] === 1'b1) rdy_cnt++;
            if (n >= 86 && (n - 86) % OS == 0 && (n - 86) / OS < 10)
                b2[(n-86)/OS] = dout[0];
            @(negedge clk);
        end
        chk("b2b_done", done_at, 80);
        chk("b2b_gap", low_at - done_at, 2);
        chk("b2b_ready_cnt", rdy_cnt, 1);
        chk("b2b_second", 32'(b2), 32'h354);
        wait_idle(200);

        send1(8'hF0);
        repeat (35) @(negedge clk);
        chk("mid_bit3", 32'(dout[0]), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_line", 32'(dout), 32'hF);
        chk("async_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'hF);
        chk("post_rst_busy", 32'(busy), 32'h0);
        send1(8'h3C);
        watch(100);
        chk("3c_bits", 32'(smp[0][9:0]), 32'h278);
        chk("3c_done", dn[0], 80);
        wait_idle(50);

        send1(8'h96);
        b3 = '0;
        for (int i = 1; i <= 59; i++) begin
            @(negedge clk);
            if ((i + 1) % OS == OS / 2)
                b3[(i+1)/OS] = dout[0];
            tx_data = 8'($urandom);
            tx_valid = 1'($urandom_range(0, 1));
        end
        tx_valid = 1'b0;
        chk("busy_data_bits", 32'(b3), 32'h2C);
        repeat (100) @(negedge clk);
        chk("no_extra_accept", 32'(busy), 32'h0);
        wait_idle(50);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
